// File: rtl/sound_pkg.sv
// sound_pkg: shared state encoding, sample lengths and source indices for the sound arbiter.
package sound_pkg;
  localparam int SAMPLE_BITS = 3;
  localparam int DUR_W = 24;
  localparam int SRC_PADDLE = 0;
  localparam int SRC_WALL = 1;
  localparam int SRC_BLOCK = 2;
  localparam int SRC_LIFE = 3;
  localparam int SRC_GAMEOVER = 4;
  typedef enum logic [1:0] {IDLE, TRIG, PLAY} state_t;
  // Sample lengths in CLK cycles; these must track the sample bank contents.
  localparam logic [DUR_W-1:0] DURATION [8] = '{
    24'd100, 24'd8, 24'd12, 24'd20, 24'd40, 24'd0, 24'd0, 24'd0
  };
  // A zero-length entry still plays for one cycle so the counter never underflows.
  function automatic logic [DUR_W-1:0] dur_of(input logic [SAMPLE_BITS-1:0] s);
    return DURATION[s] == '0 ? DUR_W'(1) : DURATION[s];
  endfunction
endpackage

// File: rtl/sound_arbiter_prio_encoder.sv
// prio_encoder: index of the highest set request bit plus a valid flag.
module prio_encoder #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic [N-1:0] pend,
  output logic [W-1:0] idx,
  output logic         valid
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) idx = pend[i] ? W'(i) : idx;
    valid = |pend;
  end
endmodule

// File: rtl/sound_arbiter.sv
// sound_arbiter: priority arbiter from game events to sample-bank select/trigger,
// with coalescing, preemption by higher sources and mute.
module sound_arbiter #(
  parameter int NUM_SRC = 5,
  parameter int SAMPLE_BITS = sound_pkg::SAMPLE_BITS,
  parameter int DUR_BITS = 24
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NUM_SRC-1:0]     REQ,
  input  logic                   MUTE,
  output logic [SAMPLE_BITS-1:0] AUDIO_SELECT,
  output logic                   AUDIO_TRIGGER,
  output logic                   BUSY
);
  import sound_pkg::*;
  localparam int PW = sound_pkg::SAMPLE_BITS;
  state_t state;
  logic [NUM_SRC-1:0] pending, clr;
  logic [DUR_BITS-1:0] cnt;
  logic [SAMPLE_BITS-1:0] grant;
  logic valid, launch;
  prio_encoder #(.N(NUM_SRC), .W(SAMPLE_BITS)) u_enc (
    .pend(pending),
    .idx(grant),
    .valid(valid)
  );
  // Start a new sound from idle, at end of play, or when a strictly higher source preempts.
  always_comb begin
    launch = !MUTE && valid && (state == IDLE || grant > AUDIO_SELECT || (state == PLAY && cnt == '0));
    clr = launch ? NUM_SRC'(1) << grant : '0;
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      pending <= '0;
      cnt <= '0;
      AUDIO_SELECT <= '0;
      AUDIO_TRIGGER <= 1'b0;
      BUSY <= 1'b0;
    end else begin
      pending <= MUTE ? '0 : (pending & ~clr) | REQ;
      AUDIO_TRIGGER <= launch;
      if (launch) begin
        state <= TRIG;
        AUDIO_SELECT <= grant;
        BUSY <= 1'b1;
      end else if (MUTE || state == IDLE || (state == PLAY && cnt == '0)) begin
        state <= IDLE;
        BUSY <= 1'b0;
      end else if (state == TRIG) begin
        state <= PLAY;
        cnt <= DUR_BITS'(dur_of(PW'(AUDIO_SELECT))) - DUR_BITS'(1);
      end else begin
        cnt <= cnt - DUR_BITS'(1);
      end
    end
  end
endmodule

// File: tb/tb_sound_arbiter.sv
// tb_sound_arbiter: directed scenarios for sound_arbiter with hand-computed trigger timing.
`timescale 1ns/100ps
module tb_sound_arbiter;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic MUTE = 1'b0;
  logic [4:0] REQ = '0;
  logic [2:0] AUDIO_SELECT;
  logic AUDIO_TRIGGER, BUSY;
  int tests = 0, fails = 0, cyc = 0, nbusy = 0;
  int tq_sel[$];
  int tq_cyc[$];

  sound_arbiter dut (
    .CLK(CLK),
    .RESET(RESET),
    .REQ(REQ),
    .MUTE(MUTE),
    .AUDIO_SELECT(AUDIO_SELECT),
    .AUDIO_TRIGGER(AUDIO_TRIGGER),
    .BUSY(BUSY)
  );

  always #12.5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    if (AUDIO_TRIGGER) begin
      tq_sel.push_back(int'(AUDIO_SELECT));
      tq_cyc.push_back(cyc);
    end
    if (BUSY) nbusy++;
  endtask

  task automatic pulse(input logic [4:0] r);
    REQ = r;
    tick();
    REQ = '0;
  endtask

  task automatic do_reset();
    REQ = '0;
    MUTE = 1'b0;
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    tq_sel.delete();
    tq_cyc.delete();
    nbusy = 0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    REQ = 5'b11111;
    tick();
    tick();
    tests++;
    if (AUDIO_SELECT !== 3'd0 || AUDIO_TRIGGER !== 1'b0 || BUSY !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: sel=%0d trig=%b busy=%b, want 0 0 0", AUDIO_SELECT, AUDIO_TRIGGER, BUSY);
    end
    REQ = '0;
    RESET = 1'b0;
    tq_sel.delete();
    tq_cyc.delete();
    repeat (5) tick();
    tests++;
    if (tq_sel.size() != 0 || BUSY !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: triggers=%0d busy=%b, want 0 0", tq_sel.size(), BUSY);
    end
  endtask

  task automatic test_single();
    do_reset();
    pulse(5'b00010);
    tests++;
    if (AUDIO_TRIGGER !== 1'b0) begin
      fails++;
      $display("FAIL single_early: trig=%b, want 0", AUDIO_TRIGGER);
    end
    tick();
    tests++;
    if (AUDIO_TRIGGER !== 1'b1 || AUDIO_SELECT !== 3'd1) begin
      fails++;
      $display("FAIL single_trigger: trig=%b sel=%0d, want 1 1", AUDIO_TRIGGER, AUDIO_SELECT);
    end
    repeat (15) tick();
    tests++;
    if (nbusy != 9) begin
      fails++;
      $display("FAIL single_busy_len: got %0d cycles, want 9", nbusy);
    end
    tests++;
    if (tq_sel.size() != 1 || BUSY !== 1'b0) begin
      fails++;
      $display("FAIL single_count: triggers=%0d busy=%b, want 1 0", tq_sel.size(), BUSY);
    end
  endtask

  task automatic test_simultaneous();
    int c0;
    do_reset();
    pulse(5'b00101);
    c0 = cyc;
    repeat (20) tick();
    tests++;
    if (tq_sel.size() != 2 || tq_sel[0] != 2 || tq_sel[1] != 0) begin
      fails++;
      $display("FAIL simul_order: n=%0d first=%0d second=%0d, want 2 2 0", tq_sel.size(), tq_sel[0], tq_sel[1]);
    end
    tests++;
    if (tq_cyc[0] != c0 + 1 || tq_cyc[1] != c0 + 14) begin
      fails++;
      $display("FAIL simul_timing: got %0d %0d, want %0d %0d", tq_cyc[0], tq_cyc[1], c0 + 1, c0 + 14);
    end
  endtask

  task automatic test_preempt();
    int cm;
    do_reset();
    pulse(5'b00001);
    tick();
    repeat (30) tick();
    pulse(5'b10000);
    cm = cyc;
    repeat (150) tick();
    tests++;
    if (tq_sel.size() != 2 || tq_sel[0] != 0 || tq_sel[1] != 4) begin
      fails++;
      $display("FAIL preempt_order: n=%0d sels=%0d,%0d, want 2 0,4", tq_sel.size(), tq_sel[0], tq_sel[1]);
    end
    tests++;
    if (tq_cyc[1] != cm + 1) begin
      fails++;
      $display("FAIL preempt_latency: got cycle %0d, want %0d", tq_cyc[1], cm + 1);
    end
    tests++;
    if (BUSY !== 1'b0) begin
      fails++;
      $display("FAIL preempt_idle: busy=%b, want 0", BUSY);
    end
  endtask

  task automatic test_no_preempt();
    int t0;
    do_reset();
    pulse(5'b01000);
    tick();
    t0 = cyc;
    repeat (5) tick();
    pulse(5'b01100);
    repeat (70) tick();
    tests++;
    if (tq_sel.size() != 3 || tq_sel[0] != 3 || tq_sel[1] != 3 || tq_sel[2] != 2) begin
      fails++;
      $display("FAIL nopre_order: n=%0d sels=%0d,%0d,%0d, want 3 3,3,2", tq_sel.size(), tq_sel[0], tq_sel[1], tq_sel[2]);
    end
    tests++;
    if (tq_cyc[0] != t0 || tq_cyc[1] != t0 + 21 || tq_cyc[2] != t0 + 42) begin
      fails++;
      $display("FAIL nopre_timing: got %0d %0d %0d, want %0d %0d %0d", tq_cyc[0], tq_cyc[1], tq_cyc[2], t0, t0 + 21, t0 + 42);
    end
  endtask

  task automatic test_coalesce();
    do_reset();
    pulse(5'b01000);
    tick();
    repeat (4) begin
      tick();
      pulse(5'b00010);
    end
    repeat (50) tick();
    tests++;
    if (tq_sel.size() != 2 || tq_sel[1] != 1) begin
      fails++;
      $display("FAIL coalesce_count: n=%0d second=%0d, want 2 1", tq_sel.size(), tq_sel[1]);
    end
    tests++;
    if (tq_cyc[1] - tq_cyc[0] != 21) begin
      fails++;
      $display("FAIL coalesce_timing: gap %0d, want 21", tq_cyc[1] - tq_cyc[0]);
    end
  endtask

  task automatic test_mute();
    do_reset();
    pulse(5'b01000);
    tick();
    pulse(5'b00010);
    MUTE = 1'b1;
    tick();
    tests++;
    if (BUSY !== 1'b0 || AUDIO_TRIGGER !== 1'b0) begin
      fails++;
      $display("FAIL mute_idle: busy=%b trig=%b, want 0 0", BUSY, AUDIO_TRIGGER);
    end
    pulse(5'b00100);
    tick();
    MUTE = 1'b0;
    repeat (30) tick();
    tests++;
    if (tq_sel.size() != 1 || BUSY !== 1'b0) begin
      fails++;
      $display("FAIL mute_cleared: triggers=%0d busy=%b, want 1 0", tq_sel.size(), BUSY);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    pulse(5'b00100);
    tick();
    repeat (10) tick();
    tests++;
    if (BUSY !== 1'b1 || AUDIO_SELECT !== 3'd2) begin
      fails++;
      $display("FAIL areset_pre: busy=%b sel=%0d, want 1 2", BUSY, AUDIO_SELECT);
    end
    #5 RESET = 1'b1;
    #1;
    tests++;
    if (BUSY !== 1'b0 || AUDIO_SELECT !== 3'd0 || AUDIO_TRIGGER !== 1'b0) begin
      fails++;
      $display("FAIL areset_immediate: busy=%b sel=%0d trig=%b, want 0 0 0", BUSY, AUDIO_SELECT, AUDIO_TRIGGER);
    end
    @(negedge CLK);
    RESET = 1'b0;
    repeat (30) tick();
    tests++;
    if (tq_sel.size() != 1 || BUSY !== 1'b0) begin
      fails++;
      $display("FAIL areset_no_replay: triggers=%0d busy=%b, want 1 0", tq_sel.size(), BUSY);
    end
    pulse(5'b00010);
    tick();
    tests++;
    if (AUDIO_TRIGGER !== 1'b1 || AUDIO_SELECT !== 3'd1) begin
      fails++;
      $display("FAIL areset_new_req: trig=%b sel=%0d, want 1 1", AUDIO_TRIGGER, AUDIO_SELECT);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_preempt();
    test_no_preempt();
    test_coalesce();
    test_mute();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
